// File: rtl/mips_control_pkg.sv
// rtl/mips_control_pkg.sv - shared state codes, opcode/funct constants and ALUOp encodings
// for the multicycle MIPS control unit.
package mips_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_I_EXEC    = 4'd10,
    ST_I_WB      = 4'd11,
    ST_JR        = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] ALUOP_LUI   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_JUMP  = 3'b010;
  localparam logic [2:0] ALUOP_ADD   = 3'b011;
  localparam logic [2:0] ALUOP_ADDI  = 3'b100;
  localparam logic [2:0] ALUOP_ORI   = 3'b101;
  localparam logic [2:0] ALUOP_ANDI  = 3'b110;
  localparam logic [2:0] ALUOP_FUNCT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  // DECODE dispatch; ST_FETCH doubles as the "undecodable" result.
  function automatic state_e dispatch(input logic [5:0] opcode, input logic [5:0] funct);
    state_e nxt;
    nxt = ST_FETCH;
    case (opcode)
      OP_RTYPE:                          nxt = (funct == FUNCT_JR) ? ST_JR : ST_R_EXEC;
      OP_LW, OP_SW:                      nxt = ST_MEM_ADDR;
      OP_BEQ, OP_BNE:                    nxt = ST_BRANCH;
      OP_J:                              nxt = ST_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  nxt = ST_I_EXEC;
      default:                           nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_output_decode.sv
// rtl/multicycle_output_decode.sv - Moore output decode of the multicycle control FSM;
// opcode_i is the opcode latched in DECODE.
module multicycle_output_decode
  import mips_control_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = SRCB_BOFF;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_source = PCSRC_ALUOUT;
        ctrl_o.pc_write  = ((opcode_i == OP_BEQ) &  zero_i) |
                           ((opcode_i == OP_BNE) & ~zero_i);
      end
      ST_JUMP: begin
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_op    = ALUOP_JUMP;
      end
      ST_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        case (opcode_i)
          OP_ADDI: ctrl_o.alu_op = ALUOP_ADDI;
          OP_ANDI: ctrl_o.alu_op = ALUOP_ANDI;
          OP_ORI:  ctrl_o.alu_op = ALUOP_ORI;
          default: ctrl_o.alu_op = ALUOP_LUI;
        endcase
      end
      ST_I_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      ST_JR: begin
        ctrl_o.pc_source = PCSRC_RS;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM: state register, next-state logic,
// latched opcode and retired-instruction counter.
module multicycle_control
  import mips_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  i_Opcode,
  input  logic [5:0]  i_Funct,
  input  logic        i_Zero,
  input  logic        i_MemReady,
  output logic        o_PCWrite,
  output logic        o_IorD,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_IRWrite,
  output logic        o_RegWrite,
  output logic        o_RegDst,
  output logic        o_MemtoReg,
  output logic        o_ALUSrcA,
  output logic [1:0]  o_ALUSrcB,
  output logic [1:0]  o_PCSource,
  output logic [2:0]  o_ALUOp,
  output logic        o_IllegalOp,
  output logic [3:0]  o_State,
  output logic [31:0] o_InstrCount
);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] count_q, count_d;
  logic        illegal;
  logic        retire;
  ctrl_t       ctrl, ctrl_g;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    op_d    = op_q;
    case (state_q)
      ST_FETCH:     if (i_MemReady) state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = i_Opcode;
        state_d = dispatch(i_Opcode, i_Funct);
        illegal = (state_d == ST_FETCH);
      end
      ST_MEM_ADDR:  state_d = (op_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (i_MemReady) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (i_MemReady) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_I_EXEC:    state_d = ST_I_WB;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Any arrival in FETCH retires an instruction, except an illegal opcode bounced from DECODE.
  assign retire  = (state_q != ST_FETCH) && (state_d == ST_FETCH) && !illegal;
  assign count_d = count_q + {31'd0, retire};

  multicycle_output_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (op_q),
    .zero_i      (i_Zero),
    .mem_ready_i (i_MemReady),
    .ctrl_o      (ctrl)
  );

  // Reset is asynchronous, so strobes are masked directly rather than waiting for the state.
  assign ctrl_g = reset ? ctrl : '0;

  assign o_PCWrite    = ctrl_g.pc_write;
  assign o_IorD       = ctrl_g.iord;
  assign o_MemRead    = ctrl_g.mem_read;
  assign o_MemWrite   = ctrl_g.mem_write;
  assign o_IRWrite    = ctrl_g.ir_write;
  assign o_RegWrite   = ctrl_g.reg_write;
  assign o_RegDst     = ctrl_g.reg_dst;
  assign o_MemtoReg   = ctrl_g.mem_to_reg;
  assign o_ALUSrcA    = ctrl_g.alu_src_a;
  assign o_ALUSrcB    = ctrl_g.alu_src_b;
  assign o_PCSource   = ctrl_g.pc_source;
  assign o_ALUOp      = ctrl_g.alu_op;
  assign o_IllegalOp  = reset & illegal;
  assign o_State      = state_q;
  assign o_InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control: a per-instruction
// phase model pushes expected cycles, a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3, S_MEM_WB = 4;
  localparam int S_MEM_WRITE = 5, S_R_EXEC = 6, S_R_WB = 7, S_BRANCH = 8, S_JUMP = 9;
  localparam int S_I_EXEC = 10, S_I_WB = 11, S_JR = 12;

  localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] JMP = 6'h02, ADDI = 6'h08, ANDI = 6'h0C, ORI = 6'h0D, LUI = 6'h0F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  i_Opcode = '0, i_Funct = '0;
  logic        i_Zero = 1'b0, i_MemReady = 1'b0;
  logic        o_PCWrite, o_IorD, o_MemRead, o_MemWrite, o_IRWrite, o_RegWrite;
  logic        o_RegDst, o_MemtoReg, o_ALUSrcA, o_IllegalOp;
  logic [1:0]  o_ALUSrcB, o_PCSource;
  logic [2:0]  o_ALUOp;
  logic [3:0]  o_State;
  logic [31:0] o_InstrCount;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .i_Opcode(i_Opcode), .i_Funct(i_Funct), .i_Zero(i_Zero),
    .i_MemReady(i_MemReady), .o_PCWrite(o_PCWrite), .o_IorD(o_IorD), .o_MemRead(o_MemRead),
    .o_MemWrite(o_MemWrite), .o_IRWrite(o_IRWrite), .o_RegWrite(o_RegWrite),
    .o_RegDst(o_RegDst), .o_MemtoReg(o_MemtoReg), .o_ALUSrcA(o_ALUSrcA),
    .o_ALUSrcB(o_ALUSrcB), .o_PCSource(o_PCSource), .o_ALUOp(o_ALUOp),
    .o_IllegalOp(o_IllegalOp), .o_State(o_State), .o_InstrCount(o_InstrCount)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw, iord, mr, mw, irw, rw, rd, m2r, asa;
    logic [1:0]  asb, pcs;
    logic [2:0]  aluop;
    logic        ill;
    logic [31:0] cnt;
  } obs_t;

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_count = '0;

  function automatic obs_t model(input int st, input logic [5:0] op, input logic z,
                                 input logic rdy, input logic ill, input logic [31:0] cnt);
    obs_t o;
    o = '0;
    o.st = st[3:0];
    o.cnt = cnt;
    case (st)
      S_FETCH:     begin o.mr = 1; o.asb = 2'b01; o.aluop = 3'b011; o.irw = rdy; o.pcw = rdy; end
      S_DECODE:    begin o.asb = 2'b11; o.aluop = 3'b011; o.ill = ill; end
      S_MEM_ADDR:  begin o.asa = 1; o.asb = 2'b10; o.aluop = 3'b011; end
      S_MEM_READ:  begin o.mr = 1; o.iord = 1; end
      S_MEM_WB:    begin o.rw = 1; o.m2r = 1; end
      S_MEM_WRITE: begin o.mw = 1; o.iord = 1; end
      S_R_EXEC:    begin o.asa = 1; o.aluop = 3'b111; end
      S_R_WB:      begin o.rw = 1; o.rd = 1; end
      S_BRANCH: begin
        o.asa = 1; o.aluop = 3'b001; o.pcs = 2'b01;
        o.pcw = (op == BEQ && z) || (op == BNE && !z);
      end
      S_JUMP:      begin o.pcs = 2'b10; o.pcw = 1; o.aluop = 3'b010; end
      S_I_EXEC: begin
        o.asa = 1; o.asb = 2'b10;
        o.aluop = (op == ADDI) ? 3'b100 : (op == ANDI) ? 3'b110 : (op == ORI) ? 3'b101 : 3'b000;
      end
      S_I_WB:      o.rw = 1;
      S_JR:        begin o.pcs = 2'b11; o.pcw = 1; o.aluop = 3'b111; end
      default:     o = '0;
    endcase
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {RT, LW, SW, BEQ, BNE, JMP, ADDI, ANDI, ORI, LUI};
  endfunction

  // After DECODE the opcode/funct pins carry junk so later states must rely on the latched copy.
  task automatic step(input int st, input logic rdy, input logic ill,
                      input logic [5:0] op, input logic [5:0] fn, input logic z);
    @(posedge clk);
    #1;
    reset = 1'b1;
    i_MemReady = rdy;
    i_Zero = z;
    if (st == S_FETCH || st == S_DECODE) begin
      i_Opcode = op;
      i_Funct = fn;
    end else begin
      i_Opcode = 6'($urandom);
      i_Funct = 6'($urandom);
    end
    exp_q.push_back(model(st, op, z, rdy, ill, m_count));
  endtask

  task automatic rst_step();
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_MemReady = 1'($urandom);
    m_count = '0;
    exp_q.push_back(model(-1, 6'd0, 1'b0, 1'b0, 1'b0, 32'd0));
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, input bit abort, input bit wrap);
    bit ill;
    ill = !is_legal(op);
    repeat (fw) step(S_FETCH, 1'b0, 1'b0, op, fn, z);
    step(S_FETCH, 1'b1, 1'b0, op, fn, z);
    step(S_DECODE, 1'($urandom), ill, op, fn, z);
    if (wrap) begin
      @(negedge clk);
      #1;
      force dut.count_q = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
    end
    if (ill) return;
    if (op == RT && fn == 6'h08) step(S_JR, 1'($urandom), 1'b0, op, fn, z);
    else if (op == RT) begin
      step(S_R_EXEC, 1'($urandom), 1'b0, op, fn, z);
      if (wrap) release dut.count_q;
      step(S_R_WB, 1'($urandom), 1'b0, op, fn, z);
    end else if (op == LW) begin
      step(S_MEM_ADDR, 1'($urandom), 1'b0, op, fn, z);
      repeat (mw) step(S_MEM_READ, 1'b0, 1'b0, op, fn, z);
      step(S_MEM_READ, 1'b1, 1'b0, op, fn, z);
      step(S_MEM_WB, 1'($urandom), 1'b0, op, fn, z);
    end else if (op == SW) begin
      step(S_MEM_ADDR, 1'($urandom), 1'b0, op, fn, z);
      repeat (mw) step(S_MEM_WRITE, 1'b0, 1'b0, op, fn, z);
      if (abort) begin
        rst_step();
        rst_step();
        return;
      end
      step(S_MEM_WRITE, 1'b1, 1'b0, op, fn, z);
    end else if (op == BEQ || op == BNE) step(S_BRANCH, 1'($urandom), 1'b0, op, fn, z);
    else if (op == JMP) step(S_JUMP, 1'($urandom), 1'b0, op, fn, z);
    else begin
      step(S_I_EXEC, 1'($urandom), 1'b0, op, fn, z);
      step(S_I_WB, 1'($urandom), 1'b0, op, fn, z);
    end
    m_count = m_count + 32'd1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t a, e;
      e = exp_q.pop_front();
      a = {o_State, o_PCWrite, o_IorD, o_MemRead, o_MemWrite, o_IRWrite, o_RegWrite,
           o_RegDst, o_MemtoReg, o_ALUSrcA, o_ALUSrcB, o_PCSource, o_ALUOp, o_IllegalOp,
           o_InstrCount};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL trace#%0d t=%0t: got %h required %h", n_checks, $time, a, e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[11];
    ops = '{RT, RT, LW, SW, BEQ, BNE, JMP, ADDI, ANDI, ORI, LUI};
    repeat (3) rst_step();
    run_instr(RT, 6'h20, 1'b0, 0, 0, 0, 0);
    run_instr(LW, 6'h00, 1'b0, 0, 3, 0, 0);
    run_instr(BEQ, 6'h00, 1'b1, 0, 0, 0, 0);
    run_instr(BEQ, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr(BNE, 6'h00, 1'b1, 0, 0, 0, 0);
    run_instr(BNE, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr(RT, 6'h08, 1'b0, 0, 0, 0, 0);
    run_instr(JMP, 6'h00, 1'b0, 1, 0, 0, 0);
    run_instr(ADDI, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr(ANDI, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr(ORI, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr(LUI, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr(SW, 6'h00, 1'b0, 0, 2, 0, 0);
    run_instr(RT, 6'h22, 1'b0, 0, 0, 0, 1);
    run_instr(ADDI, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr(SW, 6'h00, 1'b0, 0, 1, 1, 0);
    for (int k = 0; k < 80; k++) begin
      logic [5:0] op, fn;
      int sel;
      sel = int'($urandom_range(0, 12));
      fn = 6'($urandom);
      if (sel < 11) op = ops[sel];
      else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      if (op == RT && sel == 1) fn = 6'h08;
      else if (op == RT && fn == 6'h08) fn = 6'h20;
      run_instr(op, fn, 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d left required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
